aes_mask_gen: RTL and testbench

AES_MASK_GEN -- requirements
Module: aes_mask_gen

---
 rtl/aes_mask_gen_if.sv | 33 +++
 rtl/aes_mask_gen.sv | 119 +++++++++++
 tb/tb_aes_mask_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_mask_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_mask_gen_if
// Brief    : Request/response bundle between a masking core and aes_mask_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_mask_gen_if;
  logic         init;
  logic         next;
  logic [127:0] seed;
  logic [127:0] mask;
  logic         valid;
  logic         ready;

  modport master (
    output init,
    output next,
    output seed,
    input  mask,
    input  valid,
    input  ready
  );

  modport slave (
    input  init,
    input  next,
    input  seed,
    output mask,
    output valid,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/aes_mask_gen.sv
`default_nettype none
// ============================================================================
// Module   : aes_mask_gen
// Brief    : xorshift128 PRNG producing 128-bit masks on request.
// Revision : 1.0 - initial release
// ============================================================================
module aes_mask_gen #(
  parameter int WARMUP_STEPS = 16,
  parameter int GEN_STEPS    = 4
) (
  input  logic           clk,
  input  logic           reset,
  aes_mask_gen_if.slave  bus
);

  localparam logic [127:0] C_SEED_SUB  = 128'h6a09e667_bb67ae85_3c6ef372_a54ff53a;
  localparam logic [4:0]   C_WARM_LAST = 5'(WARMUP_STEPS - 1);
  localparam logic [4:0]   C_GEN_LAST  = 5'(GEN_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_GEN    = 2'd2
  } state_t;

  state_t         r_fsm;
  state_t         w_fsm_nxt;
  logic [127:0]   r_state;
  logic [127:0]   w_state_nxt;
  logic [127:0]   w_state_step;
  logic [127:0]   r_mask;
  logic [127:0]   w_mask_nxt;
  logic           r_valid;
  logic           w_valid_nxt;
  logic [4:0]     r_cnt;
  logic [4:0]     w_cnt_nxt;

  logic [31:0]    w_x;
  logic [31:0]    w_y;
  logic [31:0]    w_z;
  logic [31:0]    w_w;
  logic [31:0]    w_t;
  logic [31:0]    w_w_new;

  // One xorshift128 step; the output word is appended and x is dropped.
  always_comb begin
    w_x          = r_state[127:96];
    w_y          = r_state[95:64];
    w_z          = r_state[63:32];
    w_w          = r_state[31:0];
    w_t          = w_x ^ (w_x << 11);
    w_w_new      = w_w ^ (w_w >> 19) ^ w_t ^ (w_t >> 8);
    w_state_step = {w_y, w_z, w_w, w_w_new};
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    case (r_fsm)
      ST_IDLE: begin
        if (bus.init) begin
          // An all-zero seed would lock the generator at zero forever.
          w_state_nxt = (bus.seed == 128'h0) ? C_SEED_SUB : bus.seed;
          w_fsm_nxt   = ST_WARMUP;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = 5'd0;
        end else if (bus.next) begin
          w_fsm_nxt   = ST_GEN;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = 5'd0;
        end
      end
      ST_WARMUP: begin
        w_state_nxt = w_state_step;
        w_cnt_nxt   = r_cnt + 5'd1;
        if (r_cnt == C_WARM_LAST) begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      ST_GEN: begin
        w_state_nxt = w_state_step;
        w_cnt_nxt   = r_cnt + 5'd1;
        if (r_cnt == C_GEN_LAST) begin
          w_fsm_nxt   = ST_IDLE;
          w_mask_nxt  = w_state_step;
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm   <= ST_IDLE;
      r_state <= C_SEED_SUB;
      r_mask  <= 128'h0;
      r_valid <= 1'b0;
      r_cnt   <= 5'd0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.mask  = r_mask;
  assign bus.valid = r_valid;
  assign bus.ready = (r_fsm == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_mask_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_mask_gen
// Brief    : Directed self-checking bench for aes_mask_gen (two parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_mask_gen;

  localparam logic [127:0] C_SUB    = 128'h6a09e667_bb67ae85_3c6ef372_a54ff53a;
  localparam logic [127:0] C_HAND29 = 128'h00000001_00000001_00000808_00000001;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  aes_mask_gen_if ifa ();
  aes_mask_gen_if ifb ();

  aes_mask_gen #(.WARMUP_STEPS(1), .GEN_STEPS(4)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  aes_mask_gen #(.WARMUP_STEPS(16), .GEN_STEPS(4)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] mdl_step(input logic [127:0] s);
    logic [31:0] a, b, c, d, t, e;
    a = s[127:96]; b = s[95:64]; c = s[63:32]; d = s[31:0];
    t = a ^ (a << 11);
    e = d ^ (d >> 19) ^ t ^ (t >> 8);
    return {b, c, d, e};
  endfunction

  function automatic logic [127:0] mdl_run(input logic [127:0] s, input int n);
    logic [127:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = mdl_step(r);
    return r;
  endfunction

  // Drive one request cycle; returns one cycle after the accepting edge.
  task automatic pulse(input int sel, input logic i, input logic n, input logic [127:0] s);
    @(negedge clk);
    if (sel == 0) begin
      ifa.init = i; ifa.next = n; ifa.seed = s;
    end else begin
      ifb.init = i; ifb.next = n; ifb.seed = s;
    end
    @(posedge clk);
    #1;
    ifa.init = 1'b0; ifa.next = 1'b0;
    ifb.init = 1'b0; ifb.next = 1'b0;
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ifa.ready : ifb.ready;
  endfunction

  task automatic wait_ready(input int sel, output int n);
    n = 0;
    while (!rdy(sel) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int           lat;
  logic [127:0] m;
  logic [127:0] prev_mask;

  initial begin
    ifa.init = 1'b0; ifa.next = 1'b0; ifa.seed = '0;
    ifb.init = 1'b0; ifb.next = 1'b0; ifb.seed = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Idle after reset: mask=0, valid=0, ready=1 for 20 cycles.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check("rst_idle", {ifb.mask, ifb.valid, ifb.ready}, {128'h0, 1'b0, 1'b1});
    end

    // Next before any init steps from the substitution constant.
    pulse(1, 1'b0, 1'b1, '0);
    check("pre_init_busy", {ifb.ready, ifb.valid}, 2'b00);
    wait_ready(1, lat);
    check("pre_init_lat", lat, 4);
    m = mdl_run(C_SUB, 4);
    check("pre_init_mask", {ifb.mask, ifb.valid}, {m, 1'b1});

    // Hand-computed vector, WARMUP_STEPS=1.
    pulse(0, 1'b1, 1'b0, 128'h1);
    wait_ready(0, lat);
    check("a_warm_lat", lat, 1);
    check("a_warm_out", {ifa.mask, ifa.valid}, {128'h0, 1'b0});
    pulse(0, 1'b0, 1'b1, '0);
    wait_ready(0, lat);
    check("a_gen_lat", lat, 4);
    check("a_gen_mask", {ifa.mask, ifa.valid}, {C_HAND29, 1'b1});

    // Default timing: 16-cycle warmup leaves mask untouched, 4-cycle gen.
    prev_mask = m;
    pulse(1, 1'b1, 1'b0, 128'h01234567_89abcdef_fedcba98_76543210);
    check("b_init_t1", {ifb.ready, ifb.valid}, 2'b00);
    wait_ready(1, lat);
    check("b_warm_lat", lat, 16);
    check("b_warm_out", {ifb.mask, ifb.valid}, {prev_mask, 1'b0});
    m = mdl_run(128'h01234567_89abcdef_fedcba98_76543210, 16);
    pulse(1, 1'b0, 1'b1, '0);
    wait_ready(1, lat);
    check("b_gen_lat", lat, 4);
    m = mdl_run(m, 4);
    check("b_gen_mask", {ifb.mask, ifb.valid}, {m, 1'b1});

    // Busy-time requests are dropped, not queued.
    pulse(1, 1'b1, 1'b0, 128'hdeadbeef_00000000_00000000_00000001);
    pulse(1, 1'b0, 1'b1, '0);
    pulse(1, 1'b1, 1'b0, 128'h11111111_22222222_33333333_44444444);
    wait_ready(1, lat);
    check("busy_lat", lat + 2, 16);
    check("busy_valid", ifb.valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("busy_no_queue", ifb.ready, 1'b1);
    m = mdl_run(128'hdeadbeef_00000000_00000000_00000001, 16);
    pulse(1, 1'b0, 1'b1, '0);
    wait_ready(1, lat);
    m = mdl_run(m, 4);
    check("busy_mask", {ifb.mask, ifb.valid}, {m, 1'b1});

    // Simultaneous init+next: init wins.
    pulse(1, 1'b1, 1'b1, 128'hcafef00d_0badc0de_13572468_9abcdef0);
    wait_ready(1, lat);
    check("both_lat", lat, 16);
    check("both_valid", ifb.valid, 1'b0);
    m = mdl_run(128'hcafef00d_0badc0de_13572468_9abcdef0, 16);
    pulse(1, 1'b0, 1'b1, '0);
    wait_ready(1, lat);
    m = mdl_run(m, 4);
    check("both_mask", {ifb.mask, ifb.valid}, {m, 1'b1});

    // Zero seed and explicit constant seed give the same mask sequence.
    for (int run = 0; run < 2; run++) begin
      pulse(1, 1'b1, 1'b0, (run == 0) ? 128'h0 : C_SUB);
      wait_ready(1, lat);
      m = mdl_run(C_SUB, 16);
      for (int g = 0; g < 8; g++) begin
        pulse(1, 1'b0, 1'b1, '0);
        wait_ready(1, lat);
        m = mdl_run(m, 4);
        check((run == 0) ? "seq_zero" : "seq_const", {ifb.mask, ifb.valid}, {m, 1'b1});
      end
    end

    // Reset in the second GEN cycle, with a competing init on the same edge.
    pulse(0, 1'b0, 1'b1, '0);
    @(negedge clk);
    rst_a = 1'b1;
    ifa.init = 1'b1;
    ifa.seed = 128'h55;
    @(posedge clk);
    #1;
    check("abort_out", {ifa.mask, ifa.valid, ifa.ready}, {128'h0, 1'b0, 1'b1});
    @(negedge clk);
    rst_a = 1'b0;
    ifa.init = 1'b0;
    @(posedge clk);
    #1;
    check("abort_idle", {ifa.mask, ifa.valid, ifa.ready}, {128'h0, 1'b0, 1'b1});
    pulse(0, 1'b1, 1'b0, 128'h1);
    wait_ready(0, lat);
    pulse(0, 1'b0, 1'b1, '0);
    wait_ready(0, lat);
    check("abort_redo_lat", lat, 4);
    check("abort_redo_mask", {ifa.mask, ifa.valid}, {C_HAND29, 1'b1});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
